change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Return-path counterpart to the coin-accepting vending controller. Takes a change amount in cents (the value the controller reports alongside its vend flag) and drives the coin-return mechanism one coin at a time: quarters, then dimes, then nickels (greedy). Every coin pulse is handshaked with the mechanism's Ack and guarded by a jam timeout. It sits between the vending controller and the coin-return solenoids.

Parameters:
AMT_W, 6, width of Amount and the remaining-amount register.
MAX_AMT, 50, largest legal change request in cents.
ACK_TIMEOUT, 16, cycles spent in EMIT without Ack before a jam error is declared.
GAP_CYC, 1, idle cycles with all coin outputs low between consecutive coins (≥1).

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-high reset.
Start  in  1  request strobe; sampled only in IDLE.
Amount  in  AMT_W  change to return in cents; latched on an accepted Start.
Ack  in  1  mechanism confirms the current coin has been released.
QOut  out  1  release-quarter command.
DOut  out  1  release-dime command.
NOut  out  1  release-nickel command.
Busy  out  1  high in every state except IDLE.
Done  out  1  one-cycle pulse when the request completes successfully.
Err  out  1  one-cycle pulse when the request is aborted.
ErrCode  out  2  00 none, 01 illegal amount, 10 jam; holds until the next accepted Start.
Coins  out  4  coins dispensed for the current or last request.

Behaviour:
- Reset (async, Rst=1): state IDLE, Rem=0, Coins=0, ErrCode=00, timer=0. All of QOut, DOut, NOut, Busy, Done and Err are 0. Rst deasserting has no other side effect.
- Outputs are Moore-type: decoded from registered state and coin-select only. No combinational path from any input to any output.
- States: IDLE, CHECK, EMIT, GAP, DONE, ERR.
- IDLE, Start=1: Rem<=Amount, Coins<=0, ErrCode<=00, go CHECK. Start in any other state is ignored; there is no queueing.
- CHECK, one cycle:
  - Rem>MAX_AMT or Rem mod 5 ≠ 0: go ERR with code 01.
  - Rem==0: go DONE.
  - Otherwise latch Sel: Q if Rem≥25, else D if Rem≥10, else N. Clear timer, go EMIT.
- EMIT: the output matching Sel is 1 and the other two are 0. The timer increments each cycle.
  - Ack=1: Rem<=Rem−value(Sel), Coins<=Coins+1, go GAP.
  - Timer reaches ACK_TIMEOUT−1 with Ack=0: go ERR with code 10. Rem and Coins keep their values.
  - If Ack arrives on the same cycle as the timeout, Ack wins.
- GAP: all coin outputs 0 for GAP_CYC cycles, then go CHECK. Ack is ignored here.
- DONE: Done=1 for one cycle, then go IDLE.
- ERR: Err=1 for one cycle, ErrCode is loaded, then go IDLE.
- Ack outside EMIT is ignored.
- Arithmetic: Rem is unsigned AMT_W bits. Subtraction cannot underflow because of the CHECK guards. Coins saturates at 15.
- Latency, Amount=A legal, Ack returned in the first EMIT cycle:
  - Per coin: 1 (CHECK) + 1 (EMIT) + GAP_CYC.
  - Plus 1 initial accept cycle, plus a final CHECK and a DONE cycle.
  - Amount=0 gives Done 2 cycles after Start is sampled.
- Reset mid-operation: every coin output drops immediately (async) and the request is abandoned without Done or Err.

Decomposition:
- Shared package (vend_pkg):
  - state encoding;
  - coin value constants (NICKEL=5, DIME=10, QUARTER=25);
  - 2-bit coin-select encoding;
  - ErrCode constants.
- Sub-module: coin_timeout_ctr, a loadable counter with clear, enable and terminal-count flag, parameterised by ACK_TIMEOUT. The top FSM instantiates it once.

Test Plan:
1. Amount=40, Start, Ack returned 1 cycle after each coin output rises -> QOut, DOut, NOut pulses in that order, each followed by a GAP cycle; Done pulse; Coins=3; ErrCode=00.
2. Amount=0 -> no coin output; Done 2 cycles after Start; Coins=0.
3. Amount=7, then Amount=55 -> each gives an Err pulse with ErrCode=01 and no coin output; Busy is 1 for exactly 2 cycles.
4. Amount=15, Ack never asserted -> DOut held for 16 cycles, then Err with ErrCode=10, Coins=0, Busy drops the next cycle.
5. Amount=50 with Ack delayed 5 cycles per coin; Start re-pulsed at 30 and Ack toggled during GAP -> exactly two QOut pulses, each 6 cycles long; the extra Start and stray Ack are ignored; Done fires; Coins=2.
6. Amount=35, Rst asserted asynchronously mid-EMIT of the first quarter -> QOut drops without waiting for a clock edge; state IDLE, Coins=0, no Done or Err; a following Amount=10 request then completes normally with one dime.

Source files
------------

// File: rtl/vend_pkg.sv
// ============================================================================
//  Module   : vend_pkg
//  Purpose  : Shared encodings for the vending return path: FSM states,
//             coin-select codes, coin values and error codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_check = 3'd1;
    localparam logic [2:0] c_st_emit  = 3'd2;
    localparam logic [2:0] c_st_gap   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_err   = 3'd5;

    localparam logic [1:0] c_sel_none = 2'd0;
    localparam logic [1:0] c_sel_q    = 2'd1;
    localparam logic [1:0] c_sel_d    = 2'd2;
    localparam logic [1:0] c_sel_n    = 2'd3;

    localparam int NICKEL  = 5;
    localparam int DIME    = 10;
    localparam int QUARTER = 25;

    localparam logic [1:0] c_err_none = 2'b00;
    localparam logic [1:0] c_err_amt  = 2'b01;
    localparam logic [1:0] c_err_jam  = 2'b10;

    function automatic int coin_value(input logic [1:0] sel);
        case (sel)
            c_sel_q: coin_value = QUARTER;
            c_sel_d: coin_value = DIME;
            c_sel_n: coin_value = NICKEL;
            default: coin_value = 0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/coin_timeout_ctr.sv
// ============================================================================
//  Module   : coin_timeout_ctr
//  Purpose  : Loadable up-counter with clear/enable; tc flags ACK_TIMEOUT-1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_timeout_ctr #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                                        Clk,
    input  logic                                        Rst,
    input  logic                                        clr,
    input  logic                                        en,
    input  logic                                        ld,
    input  logic [((ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1)-1:0] ld_val,
    output logic                                        tc
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (ld)
            r_cnt <= ld_val;
        else if (en)
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc = (r_cnt == CW'(ACK_TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
//  Module   : change_dispenser
//  Purpose  : Greedy coin-return sequencer (Q, D, N) with Ack handshake,
//             jam timeout and inter-coin gap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int MAX_AMT     = 50,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYC     = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [AMT_W-1:0] Amount,
    input  logic             Ack,
    output logic             QOut,
    output logic             DOut,
    output logic             NOut,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [1:0]       ErrCode,
    output logic [3:0]       Coins
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [AMT_W-1:0] c_max     = AMT_W'(MAX_AMT);
    localparam logic [AMT_W-1:0] c_five    = AMT_W'(NICKEL);
    localparam logic [AMT_W-1:0] c_quarter = AMT_W'(QUARTER);
    localparam logic [AMT_W-1:0] c_dime    = AMT_W'(DIME);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [AMT_W-1:0] r_rem;
    logic [3:0]       r_coins;
    logic [1:0]       r_err_code;
    logic [1:0]       r_sel;
    logic [GW-1:0]    r_gap_cnt;
    logic             w_tc;
    logic             w_illegal;
    logic             w_gap_done;
    logic [1:0]       w_sel_nxt;
    logic [AMT_W-1:0] w_coin_val;

    assign w_illegal  = (r_rem > c_max) || ((r_rem % c_five) != '0);
    assign w_gap_done = (r_gap_cnt == GW'(GAP_CYC - 1));
    assign w_sel_nxt  = (r_rem >= c_quarter) ? c_sel_q :
                        (r_rem >= c_dime)    ? c_sel_d : c_sel_n;
    assign w_coin_val = AMT_W'(coin_value(r_sel));

    coin_timeout_ctr #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .Clk    (Clk),
        .Rst    (Rst),
        .clr    (r_state == c_st_check),
        .en     (r_state == c_st_emit),
        .ld     (1'b0),
        .ld_val ('0),
        .tc     (w_tc)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (Start) w_state_nxt = c_st_check;
            c_st_check: begin
                if (w_illegal)          w_state_nxt = c_st_err;
                else if (r_rem == '0)   w_state_nxt = c_st_done;
                else                    w_state_nxt = c_st_emit;
            end
            // Ack takes priority over a coincident timeout.
            c_st_emit: begin
                if (Ack)                w_state_nxt = c_st_gap;
                else if (w_tc)          w_state_nxt = c_st_err;
            end
            c_st_gap:   if (w_gap_done) w_state_nxt = c_st_check;
            c_st_done:  w_state_nxt = c_st_idle;
            c_st_err:   w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rem      <= '0;
            r_coins    <= '0;
            r_err_code <= c_err_none;
            r_sel      <= c_sel_none;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: if (Start) begin
                    r_rem      <= Amount;
                    r_coins    <= '0;
                    r_err_code <= c_err_none;
                end
                c_st_check: begin
                    if (w_illegal)
                        r_err_code <= c_err_amt;
                    else if (r_rem != '0)
                        r_sel <= w_sel_nxt;
                end
                c_st_emit: begin
                    if (Ack) begin
                        r_rem     <= r_rem - w_coin_val;
                        r_coins   <= (r_coins == 4'hF) ? r_coins : r_coins + 4'd1;
                        r_gap_cnt <= '0;
                    end else if (w_tc) begin
                        r_err_code <= c_err_jam;
                    end
                end
                c_st_gap: r_gap_cnt <= r_gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        QOut    = (r_state == c_st_emit) && (r_sel == c_sel_q);
        DOut    = (r_state == c_st_emit) && (r_sel == c_sel_d);
        NOut    = (r_state == c_st_emit) && (r_sel == c_sel_n);
        Busy    = (r_state != c_st_idle);
        Done    = (r_state == c_st_done);
        Err     = (r_state == c_st_err);
        ErrCode = r_err_code;
        Coins   = r_coins;
    end

endmodule

`default_nettype wire
